// File: rtl/mmio_ctrl_hs_if.sv
// MMIO bus between the processor and the slot controller.
// The master drives the request; the slave returns read data and the completion.
interface mmio_ctrl_hs_if #(
    parameter int unsigned DW = 32
);
    logic          mmio_cs;
    logic          mmio_wr;
    logic          mmio_rd;
    logic [20:0]   mmio_addr;
    logic [DW-1:0] mmio_wr_data;
    logic [DW-1:0] mmio_rd_data;
    logic          mmio_ready;
    logic          mmio_err;

    modport master (
        output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        input  mmio_rd_data, mmio_ready, mmio_err
    );

    modport slave (
        input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
        output mmio_rd_data, mmio_ready, mmio_err
    );
endinterface

// File: rtl/mmio_ctrl_hs.sv
// MMIO slot controller with a registered request stage, per-slot ack handshake,
// wait states, a timeout watchdog and error reporting.
// Optional error logging (err_addr / err_cnt) is built when MMIO_ERR_LOG_EN is defined;
// otherwise both outputs are tied to zero and no logging flops exist.
module mmio_ctrl_hs #(
    parameter int unsigned N_SLOT   = 64,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned DW       = 32,
    parameter logic [63:0] ACK_MASK = 64'h0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_ctrl_hs_if.slave        bus,
    output logic [N_SLOT-1:0]    slot_cs,
    output logic [N_SLOT-1:0]    slot_rd,
    output logic [N_SLOT-1:0]    slot_wr,
    output logic [REG_AW-1:0]    slot_reg_addr,
    output logic [DW-1:0]        slot_wr_data,
    input  logic [N_SLOT*DW-1:0] slot_rd_data,
    input  logic [N_SLOT-1:0]    slot_ack,
    output logic [20:0]          err_addr,
    output logic [7:0]           err_cnt
);
    localparam int unsigned AW    = 21;
    localparam int unsigned SAW   = $clog2(N_SLOT);
    localparam int unsigned DEC_W = REG_AW + SAW;
    localparam int unsigned CW    = $clog2(TIMEOUT + 1);

    localparam logic [N_SLOT-1:0] ACK_EN = ACK_MASK[N_SLOT-1:0];

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STROBE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        state_q,    state_d;
    logic [SAW-1:0]    idx_q,      idx_d;
    logic              wr_op_q,    wr_op_d;
    logic [CW-1:0]     cnt_q,      cnt_d;
    logic [N_SLOT-1:0] slot_cs_q,  slot_cs_d;
    logic [N_SLOT-1:0] slot_rd_q,  slot_rd_d;
    logic [N_SLOT-1:0] slot_wr_q,  slot_wr_d;
    logic [REG_AW-1:0] reg_addr_q, reg_addr_d;
    logic [DW-1:0]     wr_data_q,  wr_data_d;
    logic [DW-1:0]     rd_data_q,  rd_data_d;
    logic              ready_q,    ready_d;
    logic              err_q,      err_d;

    logic              access_c;
    logic              bad_c;
    logic [AW-1:0]     addr_hi_c;
    logic [SAW-1:0]    new_idx_c;
    logic [N_SLOT-1:0] new_onehot_c;
    logic [DW-1:0]     sel_rd_data_c;
    logic              sel_ack_c;
    logic              sel_wait_c;

    // Request decode: any select with an op; both ops or out-of-range address is an error
    always_comb begin
        addr_hi_c = bus.mmio_addr >> DEC_W;
        access_c  = bus.mmio_cs & (bus.mmio_rd | bus.mmio_wr);
        bad_c     = (bus.mmio_rd & bus.mmio_wr) | (addr_hi_c != '0);
        new_idx_c = bus.mmio_addr[REG_AW +: SAW];
    end

    // One-hot of the incoming slot index and mux of the active slot's read data/ack
    always_comb begin
        new_onehot_c  = '0;
        sel_rd_data_c = '0;
        for (int i = 0; i < int'(N_SLOT); i++) begin
            new_onehot_c[i] = (new_idx_c == SAW'(i));
            if (idx_q == SAW'(i)) begin
                sel_rd_data_c = slot_rd_data[i*DW +: DW];
            end
        end
        sel_ack_c  = slot_ack[idx_q];
        sel_wait_c = ACK_EN[idx_q];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        wr_op_d    = wr_op_q;
        cnt_d      = cnt_q;
        slot_cs_d  = slot_cs_q;
        slot_rd_d  = '0;
        slot_wr_d  = '0;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        rd_data_d  = rd_data_q;
        ready_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                slot_cs_d = '0;
                if (access_c) begin
                    if (bad_c) begin
                        state_d   = S_RESP;
                        ready_d   = 1'b1;
                        err_d     = 1'b1;
                        rd_data_d = '0;
                    end else begin
                        state_d    = S_STROBE;
                        idx_d      = new_idx_c;
                        wr_op_d    = bus.mmio_wr;
                        reg_addr_d = bus.mmio_addr[REG_AW-1:0];
                        wr_data_d  = bus.mmio_wr_data;
                        slot_cs_d  = new_onehot_c;
                        slot_rd_d  = bus.mmio_rd ? new_onehot_c : '0;
                        slot_wr_d  = bus.mmio_wr ? new_onehot_c : '0;
                    end
                end
            end
            S_STROBE: begin
                if (!sel_wait_c || sel_ack_c) begin
                    state_d   = S_RESP;
                    ready_d   = 1'b1;
                    slot_cs_d = '0;
                    rd_data_d = wr_op_q ? '0 : sel_rd_data_c;
                end else begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end
            end
            S_WAIT: begin
                if (sel_ack_c) begin
                    state_d   = S_RESP;
                    ready_d   = 1'b1;
                    slot_cs_d = '0;
                    rd_data_d = wr_op_q ? '0 : sel_rd_data_c;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = S_RESP;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    slot_cs_d = '0;
                    rd_data_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d   = S_IDLE;
                slot_cs_d = '0;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            wr_op_q    <= 1'b0;
            cnt_q      <= '0;
            slot_cs_q  <= '0;
            slot_rd_q  <= '0;
            slot_wr_q  <= '0;
            reg_addr_q <= '0;
            wr_data_q  <= '0;
            rd_data_q  <= '0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_op_q    <= wr_op_d;
            cnt_q      <= cnt_d;
            slot_cs_q  <= slot_cs_d;
            slot_rd_q  <= slot_rd_d;
            slot_wr_q  <= slot_wr_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            rd_data_q  <= rd_data_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
        end
    end

    assign slot_cs          = slot_cs_q;
    assign slot_rd          = slot_rd_q;
    assign slot_wr          = slot_wr_q;
    assign slot_reg_addr    = reg_addr_q;
    assign slot_wr_data     = wr_data_q;
    assign bus.mmio_rd_data = rd_data_q;
    assign bus.mmio_ready   = ready_q;
    assign bus.mmio_err     = err_q;

`ifdef MMIO_ERR_LOG_EN
    logic [AW-1:0] addr_q,     addr_d;
    logic [AW-1:0] err_addr_q, err_addr_d;
    logic [7:0]    err_cnt_q,  err_cnt_d;

    // Error log: first errored address is sticky, count saturates at 255
    always_comb begin
        addr_d     = addr_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        if (state_q == S_IDLE && access_c) begin
            addr_d = bus.mmio_addr;
        end
        if (ready_d && err_d) begin
            if (err_cnt_q == 8'd0) begin
                err_addr_d = (state_q == S_IDLE) ? bus.mmio_addr : addr_q;
            end
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // Error log registers
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            err_addr_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_addr = err_addr_q;
    assign err_cnt  = err_cnt_q;
`else
    assign err_addr = '0;
    assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_mmio_ctrl_hs.sv
// Directed bench for mmio_ctrl_hs: 8 slots, slot 5 waits for an ack, TIMEOUT=8.
module tb_mmio_ctrl_hs;
    localparam int unsigned N_SLOT  = 8;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned DW      = 32;
    localparam int unsigned TIMEOUT = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [N_SLOT-1:0]    slot_cs, slot_rd, slot_wr, slot_ack;
    logic [REG_AW-1:0]    slot_reg_addr;
    logic [DW-1:0]        slot_wr_data;
    logic [N_SLOT*DW-1:0] slot_rd_data;
    logic [20:0]          err_addr;
    logic [7:0]           err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_ctrl_hs_if #(.DW(DW)) mif ();

    mmio_ctrl_hs #(
        .N_SLOT(N_SLOT), .REG_AW(REG_AW), .DW(DW),
        .ACK_MASK(64'h20), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .bus(mif),
        .slot_cs(slot_cs), .slot_rd(slot_rd), .slot_wr(slot_wr),
        .slot_reg_addr(slot_reg_addr), .slot_wr_data(slot_wr_data),
        .slot_rd_data(slot_rd_data), .slot_ack(slot_ack),
        .err_addr(err_addr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one cycle; drive and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in cycle 1 of the access
    task automatic issue(input logic rd, input logic wr, input logic [20:0] addr,
                         input logic [31:0] data);
        mif.mmio_cs      = 1'b1;
        mif.mmio_rd      = rd;
        mif.mmio_wr      = wr;
        mif.mmio_addr    = addr;
        mif.mmio_wr_data = data;
        tick();
        mif.mmio_cs = 1'b0;
        mif.mmio_rd = 1'b0;
        mif.mmio_wr = 1'b0;
    endtask

    initial begin
        int early;
        reset            = 1'b1;
        mif.mmio_cs      = 1'b0;
        mif.mmio_rd      = 1'b0;
        mif.mmio_wr      = 1'b0;
        mif.mmio_addr    = '0;
        mif.mmio_wr_data = '0;
        slot_ack         = '0;
        slot_rd_data     = '0;
        slot_rd_data[3*DW +: DW] = 32'h12345678;
        slot_rd_data[5*DW +: DW] = 32'h0000A5A5;
        slot_rd_data[2*DW +: DW] = 32'hCAFEF00D;
        repeat (3) tick();

        check("rst_ready",   64'(mif.mmio_ready),   64'd0);
        check("rst_rd_data", 64'(mif.mmio_rd_data), 64'd0);
        check("rst_cs",      64'(slot_cs),          64'd0);
        check("rst_err_cnt", 64'(err_cnt),          64'd0);
        reset = 1'b0;
        tick();

        // Write slot 2 reg 2, zero wait
        issue(1'b0, 1'b1, 21'h000042, 32'hDEADBEEF);
        check("wr_cs",       64'(slot_cs),       64'h04);
        check("wr_wr",       64'(slot_wr),       64'h04);
        check("wr_rd",       64'(slot_rd),       64'h00);
        check("wr_reg",      64'(slot_reg_addr), 64'd2);
        check("wr_data",     64'(slot_wr_data),  64'hDEADBEEF);
        check("wr_c1_ready", 64'(mif.mmio_ready), 64'd0);
        tick();
        check("wr_ready",    64'(mif.mmio_ready), 64'd1);
        check("wr_err",      64'(mif.mmio_err),   64'd0);
        check("wr_cs_drop",  64'(slot_cs),        64'd0);
        tick();
        check("wr_ready_1c", 64'(mif.mmio_ready), 64'd0);

        // Read slot 3, zero wait
        issue(1'b1, 1'b0, 21'h000061, 32'h0);
        check("rd3_rd",      64'(slot_rd),          64'h08);
        tick();
        check("rd3_ready",   64'(mif.mmio_ready),   64'd1);
        check("rd3_data",    64'(mif.mmio_rd_data), 64'h12345678);
        tick();
        check("rd3_hold",    64'(mif.mmio_rd_data), 64'h12345678);
        check("rd3_ready0",  64'(mif.mmio_ready),   64'd0);

        // Read slot 5 with ack in cycle 5; a stray slot 6 ack in between
        issue(1'b1, 1'b0, 21'h0000A7, 32'h0);
        check("ack_strobe",  64'(slot_rd),          64'h20);
        tick();
        check("ack_wait_cs", 64'(slot_cs),          64'h20);
        check("ack_wait_rd", 64'(slot_rd),          64'h00);
        slot_ack = 8'h40;
        tick();
        slot_ack = 8'h00;
        tick();
        tick();
        check("ack_c5_ready", 64'(mif.mmio_ready),  64'd0);
        slot_ack = 8'h20;
        tick();
        slot_ack = 8'h00;
        check("ack_ready",   64'(mif.mmio_ready),   64'd1);
        check("ack_err",     64'(mif.mmio_err),     64'd0);
        check("ack_data",    64'(mif.mmio_rd_data), 64'h0000A5A5);
        tick();

        // Write clears read data
        issue(1'b0, 1'b1, 21'h000041, 32'h1);
        tick();
        check("wr_clr_ready", 64'(mif.mmio_ready),   64'd1);
        check("wr_clr_data",  64'(mif.mmio_rd_data), 64'd0);
        tick();

        // Read slot 3 again so the timeout must zero the data
        issue(1'b1, 1'b0, 21'h000061, 32'h0);
        tick();
        tick();

        // Timeout on slot 5: ready in cycle 10 with err
        issue(1'b1, 1'b0, 21'h0000A3, 32'h0);
        early = 0;
        repeat (8) begin
            tick();
            if (mif.mmio_ready) early++;
        end
        check("to_no_early", 64'(early), 64'd0);
        tick();
        check("to_ready",    64'(mif.mmio_ready),   64'd1);
        check("to_err",      64'(mif.mmio_err),     64'd1);
        check("to_data",     64'(mif.mmio_rd_data), 64'd0);
        check("to_cs_drop",  64'(slot_cs),          64'd0);
`ifdef MMIO_ERR_LOG_EN
        check("to_err_cnt",  64'(err_cnt),  64'd1);
        check("to_err_addr", 64'(err_addr), 64'h0000A3);
`else
        check("to_err_cnt",  64'(err_cnt),  64'd0);
        check("to_err_addr", 64'(err_addr), 64'd0);
`endif
        tick();

        // Both ops set: no strobe, error in cycle 1
        issue(1'b1, 1'b1, 21'h000042, 32'h0);
        check("both_ready",  64'(mif.mmio_ready), 64'd1);
        check("both_err",    64'(mif.mmio_err),   64'd1);
        check("both_strobe", 64'({slot_cs, slot_rd, slot_wr}), 64'd0);
        tick();

        // Address bit 20 set
        issue(1'b1, 1'b0, 21'h100042, 32'h0);
        check("hi20_ready",  64'(mif.mmio_ready), 64'd1);
        check("hi20_err",    64'(mif.mmio_err),   64'd1);
        check("hi20_strobe", 64'({slot_cs, slot_rd, slot_wr}), 64'd0);
        tick();

        // Lowest out-of-range bit (bit 8 with 8 slots)
        issue(1'b0, 1'b1, 21'h000142, 32'h0);
        check("hi8_err",     64'(mif.mmio_err),   64'd1);
        check("hi8_strobe",  64'({slot_cs, slot_rd, slot_wr}), 64'd0);
`ifdef MMIO_ERR_LOG_EN
        check("log_cnt",     64'(err_cnt),  64'd4);
        check("log_sticky",  64'(err_addr), 64'h0000A3);
`else
        check("log_cnt",     64'(err_cnt),  64'd0);
`endif
        tick();

        // Reset during WAIT
        issue(1'b1, 1'b0, 21'h0000A0, 32'h0);
        tick();
        check("rw_wait_cs",  64'(slot_cs), 64'h20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rw_cs",       64'(slot_cs),          64'd0);
        check("rw_ready",    64'(mif.mmio_ready),   64'd0);
        check("rw_err_cnt",  64'(err_cnt),          64'd0);
        tick();
        check("rw_no_ready", 64'(mif.mmio_ready),   64'd0);
        issue(1'b0, 1'b1, 21'h000060, 32'h00000055);
        check("rw_wr",       64'(slot_wr),      64'h08);
        check("rw_wdata",    64'(slot_wr_data), 64'h55);
        tick();
        check("rw_ready2",   64'(mif.mmio_ready), 64'd1);
        check("rw_err2",     64'(mif.mmio_err),   64'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
